// File: rtl/indicator_position_to_meter.sv
// Level-indicator position to 32-segment bar pattern with per-channel peak-hold dot.
// Left-channel patterns are bit-reversed so stereo bars grow outward from the centre.
module indicator_position_to_meter #(
  parameter int unsigned peak_hold_samples = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [4:0]  i_position,
  input  logic        i_is_left,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_meter
);

  // A hold count of zero still needs a one-bit counter to stay legal.
  localparam int HOLD_W = (peak_hold_samples == 0) ? 1 : $clog2(peak_hold_samples + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(peak_hold_samples);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t            state, state_nxt;
  logic              rdy_en;
  logic              accept;
  logic [4:0]        pos_p0;
  logic              is_left_p0;
  logic [4:0]        peak_q [2];
  logic [HOLD_W-1:0] hold_q [2];
  logic [4:0]        peak_cur, peak_upd;
  logic [HOLD_W-1:0] hold_cur, hold_upd;
  logic [31:0]       raw_upd, meter_upd;

  function automatic logic [4:0] decay_peak(input logic [4:0] peak, input logic [4:0] pos);
    logic [4:0] dec;
    dec = (peak == 5'd0) ? 5'd0 : peak - 5'd1;
    return (dec < pos) ? pos : dec;
  endfunction

  function automatic logic [31:0] bar_mask(input logic [4:0] pos);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[i] = (i <= int'(pos));
    return m;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign i_ready = (state == IDLE) && rdy_en;
  assign o_valid = (state == OUT);
  assign accept  = i_valid && i_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = CALC;
      CALC:                 state_nxt = OUT;
      OUT:     if (o_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // CALC stage: peak update and pattern build for the latched channel
  always_comb begin
    peak_cur = peak_q[is_left_p0];
    hold_cur = hold_q[is_left_p0];
    peak_upd = peak_cur;
    hold_upd = hold_cur;
    if (pos_p0 >= peak_cur) begin
      peak_upd = pos_p0;
      hold_upd = HOLD_INIT;
    end else if (hold_cur != '0) begin
      hold_upd = hold_cur - 1'b1;
    end else begin
      peak_upd = decay_peak(peak_cur, pos_p0);
    end
    raw_upd   = bar_mask(pos_p0) | (32'd1 << peak_upd);
    meter_upd = is_left_p0 ? bit_rev(raw_upd) : raw_upd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      o_meter   <= '0;
      peak_q[0] <= '0;
      peak_q[1] <= '0;
      hold_q[0] <= '0;
      hold_q[1] <= '0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (state == CALC) begin
        peak_q[is_left_p0] <= peak_upd;
        hold_q[is_left_p0] <= hold_upd;
        o_meter            <= meter_upd;
      end
    end
  end

  // Input capture stage
  always_ff @(posedge clk) begin
    if (accept) begin
      pos_p0     <= i_position;
      is_left_p0 <= i_is_left;
    end
  end

endmodule

// File: tb/tb_indicator_position_to_meter.sv
// Directed bench for indicator_position_to_meter: three instances with hold counts 3, 16 and 0.
module tb_indicator_position_to_meter;

  logic        clk;
  logic        reset;
  logic        i_valid    [3];
  logic        i_ready    [3];
  logic [4:0]  i_position [3];
  logic        i_is_left  [3];
  logic        o_valid    [3];
  logic        o_ready    [3];
  logic [31:0] o_meter    [3];

  int tests;
  int failed;

  indicator_position_to_meter #(.peak_hold_samples(3)) u_h3 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid[0]), .i_ready(i_ready[0]), .i_position(i_position[0]), .i_is_left(i_is_left[0]),
    .o_valid(o_valid[0]), .o_ready(o_ready[0]), .o_meter(o_meter[0]));

  indicator_position_to_meter #(.peak_hold_samples(16)) u_h16 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid[1]), .i_ready(i_ready[1]), .i_position(i_position[1]), .i_is_left(i_is_left[1]),
    .o_valid(o_valid[1]), .o_ready(o_ready[1]), .o_meter(o_meter[1]));

  indicator_position_to_meter #(.peak_hold_samples(0)) u_h0 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid[2]), .i_ready(i_ready[2]), .i_position(i_position[2]), .i_is_left(i_is_left[2]),
    .o_valid(o_valid[2]), .o_ready(o_ready[2]), .o_meter(o_meter[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input int d, input logic [4:0] pos, input logic left, input logic rdy);
    int n;
    n = 0;
    while (i_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 32'(i_ready[d]), 32'd1);
    i_valid[d]    = 1'b1;
    i_position[d] = pos;
    i_is_left[d]  = left;
    o_ready[d]    = rdy;
    @(negedge clk);
    i_valid[d] = 1'b0;
    chk("ready_drop", 32'(i_ready[d]), 32'd0);
    n = 0;
    while (o_valid[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd1);
  endtask

  task automatic send(input int d, input logic [4:0] pos, input logic left,
                      input logic [31:0] exp, input string tag);
    launch(d, pos, left, 1'b1);
    chk(tag, o_meter[d], exp);
    @(negedge clk);
    chk("vld_drop", 32'(o_valid[d]), 32'd0);
  endtask

  logic [4:0]  seq_pos [7] = '{5'd31, 5'd10, 5'd13, 5'd9, 5'd3, 5'd2, 5'd1};
  logic [31:0] exp_r   [7] = '{32'hFFFFFFFF, 32'h800007FF, 32'h80003FFF, 32'h800003FF,
                               32'h4000000F, 32'h20000007, 32'h10000003};
  logic [31:0] exp_l   [7] = '{32'hFFFFFFFF, 32'hFFE00001, 32'hFFFC0001, 32'hFFC00001,
                               32'hF0000002, 32'hE0000004, 32'hC0000008};

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      i_valid[d]    = 1'b0;
      i_position[d] = '0;
      i_is_left[d]  = 1'b0;
      o_ready[d]    = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst_ovalid", 32'(o_valid[0]), 32'd0);
    chk("rst_meter", o_meter[0], 32'd0);
    chk("rst_iready", 32'(i_ready[1]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_iready", 32'(i_ready[1]), 32'd1);

    send(1, 5'd0, 1'b0, 32'h00000001, "first_zero");

    for (int k = 0; k < 7; k++) send(0, seq_pos[k], 1'b0, exp_r[k], "right_seq");
    for (int k = 0; k < 7; k++) send(0, seq_pos[k], 1'b1, exp_l[k], "left_seq");

    send(1, 5'd20, 1'b0, 32'h001FFFFF, "indep_r20");
    send(1, 5'd5,  1'b1, 32'hFC000000, "indep_l5");
    send(1, 5'd0,  1'b0, 32'h00100001, "indep_r0");

    send(2, 5'd8, 1'b0, 32'h000001FF, "h0_r8");
    send(2, 5'd2, 1'b0, 32'h00000087, "h0_r2");

    // Left 3 under peak 5: bar 0..3 plus dot at 5, mirrored.
    launch(1, 5'd3, 1'b1, 1'b0);
    chk("bp_meter0", o_meter[1], 32'hF4000000);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        i_valid[1]    = 1'b1;
        i_position[1] = 5'd31;
        i_is_left[1]  = 1'b0;
      end else begin
        i_valid[1] = 1'b0;
      end
      @(negedge clk);
      chk("bp_valid", 32'(o_valid[1]), 32'd1);
      chk("bp_meter", o_meter[1], 32'hF4000000);
      chk("bp_iready", 32'(i_ready[1]), 32'd0);
    end
    i_valid[1] = 1'b0;
    o_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(o_valid[1]), 32'd0);
    chk("bp_release_ready", 32'(i_ready[1]), 32'd1);
    chk("bp_meter_kept", o_meter[1], 32'hF4000000);
    send(1, 5'd0, 1'b0, 32'h00100001, "bp_no_effect");

    launch(0, 5'd20, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(o_valid[0]), 32'd0);
    chk("midrst_meter", o_meter[0], 32'd0);
    reset      = 1'b1;
    o_ready[0] = 1'b1;
    @(negedge clk);
    send(0, 5'd3, 1'b0, 32'h0000000F, "midrst_peak0");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
